// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the keypad BCD calculator.
//   KEY_*    : keypad key codes used by the entry state machine
//   stage_t  : calculator stage, also presented on the `stage` output
//   is_digit : true for the decimal key codes 0..9
package bcd_calc_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_END  = 4'hC;
  localparam logic [3:0] KEY_CLR  = 4'hE;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } stage_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// Single-digit BCD adder/subtractor (purely combinational).
//   a, b  : BCD digits (0..9)
//   cin   : incoming carry (add) or borrow (subtract)
//   sub   : 0 = a + b + cin, 1 = a - b - cin
//   digit : corrected BCD result digit
//   cout  : outgoing carry (add) or borrow (subtract)
module bcd_digit_alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] raw;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value held (which would infer a latch).
  always_comb begin
    raw   = 5'd0;
    digit = 4'd0;
    cout  = 1'b0;
    if (sub) begin
      // a - b - cin spans -10..9; bit 4 of the 5-bit result is the borrow.
      raw   = {1'b0, a} - {1'b0, b} - {4'd0, cin};
      cout  = raw[4];
      digit = raw[4] ? raw[3:0] + 4'd10 : raw[3:0];
    end else begin
      // a + b + cin spans 0..19; adding 6 skips the six unused codes.
      raw   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      cout  = (raw > 5'd9);
      digit = cout ? raw[3:0] + 4'd6 : raw[3:0];
    end
  end

endmodule

// File: rtl/bcd_key_calc.sv
// Keypad BCD calculator: captures two DIGITS-digit decimal operands from
// keypad codes, adds or subtracts them digit-serially, and shows the result.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   sample   : keypad key code, 4'hF = no key
//   op_a     : operand A, BCD, MSD in the top nibble
//   op_b     : operand B, BCD
//   cdu      : result magnitude, DIGITS+1 BCD digits (valid while done = 1)
//   neg      : result is negative
//   sub_mode : latched operation, 0 = add, 1 = subtract
//   stage    : 0 ENTER_A, 1 ENTER_B, 2 CALC, 3 SHOW
//   done     : high while in SHOW
module bcd_key_calc #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            sample,
  output logic [4*DIGITS-1:0]   op_a,
  output logic [4*DIGITS-1:0]   op_b,
  output logic [4*DIGITS+3:0]   cdu,
  output logic                  neg,
  output logic                  sub_mode,
  output logic [1:0]            stage,
  output logic                  done
);

  import bcd_calc_pkg::*;

  localparam int OW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);
  localparam logic [CW-1:0] FINAL_STEP = CW'(DIGITS);

  stage_t state, state_next;

  logic [3:0]    s_q, s_qq;
  logic          press, digit_ev, end_ev, clr_ev, mode_ev;
  logic          op_done, swap;
  logic [CW-1:0] cnt;     // digits entered into the active operand
  logic [CW-1:0] k;       // serial digit index during CALC
  logic          carry;   // carry/borrow between serial digits
  logic [OW-1:0] x, y;    // ordered operands, shifted right one digit per step
  logic [OW-1:0] b_final;
  logic [3:0]    alu_digit;
  logic          alu_cout;

  function automatic logic [OW-1:0] shift_in(input logic [OW-1:0] v,
                                             input logic [3:0]    d);
    return OW'({v, d});
  endfunction

  // One event per press: key present now, idle one cycle earlier.
  assign press    = (s_q != KEY_NONE) && (s_qq == KEY_NONE);
  assign digit_ev = press && is_digit(s_q);
  assign end_ev   = press && (s_q == KEY_END);
  assign clr_ev   = press && (s_q == KEY_CLR);
  assign mode_ev  = press && ((s_q == KEY_ADD) || (s_q == KEY_SUB));
  assign op_done  = end_ev || (digit_ev && (cnt == LAST_DIGIT));

  // B as it will be after this edge, so ordering sees the final digit.
  assign b_final  = digit_ev ? shift_in(op_b, s_q) : op_b;
  assign swap     = sub_mode && (op_a < b_final);

  assign stage = state;
  assign done  = (state == SHOW);

  bcd_digit_alu u_alu (
    .a     (x[3:0]),
    .b     (y[3:0]),
    .cin   (carry),
    .sub   (sub_mode),
    .digit (alu_digit),
    .cout  (alu_cout)
  );

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ENTER_A;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ENTER_A: begin
        if (clr_ev)       state_next = ENTER_A;
        else if (op_done) state_next = ENTER_B;
      end
      ENTER_B: begin
        if (clr_ev)       state_next = ENTER_A;
        else if (op_done) state_next = CALC;
      end
      CALC: begin
        if (k == FINAL_STEP) state_next = SHOW;
      end
      SHOW: begin
        if (clr_ev)        state_next = ENTER_A;
        else if (digit_ev) state_next = (DIGITS == 1) ? ENTER_B : ENTER_A;
      end
      default: state_next = ENTER_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= KEY_NONE;
      s_qq     <= KEY_NONE;
      op_a     <= '0;
      op_b     <= '0;
      cdu      <= '0;
      neg      <= 1'b0;
      sub_mode <= 1'b0;
      cnt      <= '0;
      k        <= '0;
      carry    <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      s_q  <= sample;
      s_qq <= s_q;
      case (state)
        ENTER_A, ENTER_B: begin
          if (clr_ev) begin
            op_a <= '0;
            op_b <= '0;
            cdu  <= '0;
            neg  <= 1'b0;
            cnt  <= '0;
          end else begin
            if (mode_ev) sub_mode <= (s_q == KEY_SUB);
            if (digit_ev) begin
              if (state == ENTER_A) op_a <= shift_in(op_a, s_q);
              else                  op_b <= b_final;
            end
            if (op_done)       cnt <= '0;
            else if (digit_ev) cnt <= cnt + 1'b1;
            if ((state == ENTER_B) && op_done) begin
              // Subtract always runs larger minus smaller; neg records a swap.
              x     <= swap ? b_final : op_a;
              y     <= swap ? op_a : b_final;
              neg   <= swap;
              k     <= '0;
              carry <= 1'b0;
            end
          end
        end
        CALC: begin
          if (k == FINAL_STEP) begin
            cdu[OW +: 4] <= sub_mode ? 4'd0 : {3'd0, carry};
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (k == CW'(i)) cdu[4*i +: 4] <= alu_digit;
            end
            carry <= alu_cout;
            x     <= x >> 4;
            y     <= y >> 4;
            k     <= k + 1'b1;
          end
        end
        SHOW: begin
          if (mode_ev) sub_mode <= (s_q == KEY_SUB);
          if (clr_ev) begin
            op_a <= '0;
            op_b <= '0;
            cdu  <= '0;
            neg  <= 1'b0;
            cnt  <= '0;
          end else if (digit_ev) begin
            // The new digit starts a fresh operand A.
            op_a <= OW'(s_q);
            op_b <= '0;
            cdu  <= '0;
            cnt  <= (DIGITS == 1) ? '0 : CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_key_calc.sv
// Bench for bcd_key_calc: one key stream drives a DIGITS=3 and a DIGITS=5
// instance. A decimal-arithmetic model predicts each calculation; results are
// queued and checked by per-instance monitors when done rises.
module tb_bcd_key_calc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sample = 4'hF;

  logic [11:0] op_a3, op_b3;
  logic [15:0] cdu3;
  logic        neg3, sub3, done3;
  logic [1:0]  stage3;

  logic [19:0] op_a5, op_b5;
  logic [23:0] cdu5;
  logic        neg5, sub5, done5;
  logic [1:0]  stage5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_key_calc #(.DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .sample(sample), .op_a(op_a3), .op_b(op_b3),
    .cdu(cdu3), .neg(neg3), .sub_mode(sub3), .stage(stage3), .done(done3)
  );

  bcd_key_calc #(.DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .sample(sample), .op_a(op_a5), .op_b(op_b5),
    .cdu(cdu5), .neg(neg5), .sub_mode(sub5), .stage(stage5), .done(done5)
  );

  typedef struct {
    logic [31:0] cdu;
    logic        neg;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];

  // Model state per instance (index 0: 3 digits, 1: 5 digits), held as plain
  // decimal integers. Stage 0/1 = entering A/B, 3 = showing a result.
  int   m_dig[2] = '{3, 5};
  int   m_a[2], m_b[2], m_cnt[2], m_stage[2], m_res[2];
  logic m_sub[2], m_neg[2];
  logic calc_flag = 1'b0;
  logic [3:0] prev_key = 4'hF;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_a[c] = 0; m_b[c] = 0; m_cnt[c] = 0; m_stage[c] = 0; m_res[c] = 0;
      m_sub[c] = 1'b0; m_neg[c] = 1'b0;
    end
  endtask

  task automatic model_clear(input int c);
    m_a[c] = 0; m_b[c] = 0; m_cnt[c] = 0; m_stage[c] = 0; m_res[c] = 0;
    m_neg[c] = 1'b0;
  endtask

  task automatic finish_operand(input int c);
    exp_t e;
    m_cnt[c] = 0;
    if (m_stage[c] == 0) begin
      m_stage[c] = 1;
    end else begin
      if (m_sub[c] && (m_a[c] < m_b[c])) begin
        m_res[c] = m_b[c] - m_a[c];
        m_neg[c] = 1'b1;
      end else begin
        m_res[c] = m_sub[c] ? m_a[c] - m_b[c] : m_a[c] + m_b[c];
        m_neg[c] = 1'b0;
      end
      m_stage[c] = 3;
      e.cdu = to_bcd(m_res[c], m_dig[c] + 1);
      e.neg = m_neg[c];
      e.a   = to_bcd(m_a[c], m_dig[c]);
      e.b   = to_bcd(m_b[c], m_dig[c]);
      if (c == 0) q3.push_back(e);
      else        q5.push_back(e);
      calc_flag = 1'b1;
    end
  endtask

  task automatic model_key(input int c, input logic [3:0] k);
    if (m_stage[c] == 3) begin
      if (k <= 4'd9) begin
        m_a[c] = int'(k); m_b[c] = 0; m_res[c] = 0; m_cnt[c] = 1; m_stage[c] = 0;
      end else if (k == 4'hE) model_clear(c);
      else if (k == 4'hA) m_sub[c] = 1'b0;
      else if (k == 4'hB) m_sub[c] = 1'b1;
    end else begin
      if (k <= 4'd9) begin
        if (m_stage[c] == 0) m_a[c] = m_a[c] * 10 + int'(k);
        else                 m_b[c] = m_b[c] * 10 + int'(k);
        m_cnt[c]++;
        if (m_cnt[c] == m_dig[c]) finish_operand(c);
      end else if (k == 4'hA) m_sub[c] = 1'b0;
      else if (k == 4'hB) m_sub[c] = 1'b1;
      else if (k == 4'hC) finish_operand(c);
      else if (k == 4'hE) model_clear(c);
    end
  endtask

  // One clock of stimulus; the model sees the same press events as the DUT.
  task automatic drive(input logic [3:0] key);
    @(negedge clk);
    sample = key;
    if ((key != 4'hF) && (prev_key == 4'hF)) begin
      model_key(0, key);
      model_key(1, key);
    end
    prev_key = key;
  endtask

  task automatic idle_gap(input int gap);
    int g;
    g = gap;
    if (calc_flag && (g < 12)) g = 12;
    calc_flag = 1'b0;
    repeat (g) drive(4'hF);
  endtask

  task automatic press(input logic [3:0] key, input int hold, input int gap);
    repeat (hold) drive(key);
    idle_gap(gap);
  endtask

  task automatic keys(input logic [3:0] seq[$]);
    foreach (seq[i]) press(seq[i], 1, 2);
  endtask

  task automatic check_cfg(input string tag, input int c, input logic [1:0] st,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic n, input logic s,
                           input logic d);
    string p;
    p = $sformatf("%s_d%0d", tag, m_dig[c]);
    check({p, "_stage"}, 32'(st), 32'(m_stage[c]));
    check({p, "_op_a"}, a, to_bcd(m_a[c], m_dig[c]));
    check({p, "_op_b"}, b, to_bcd(m_b[c], m_dig[c]));
    check({p, "_cdu"}, r, to_bcd(m_res[c], m_dig[c] + 1));
    check({p, "_sub_mode"}, 32'(s), 32'(m_sub[c]));
    check({p, "_done"}, 32'(d), 32'(m_stage[c] == 3));
    if (m_stage[c] == 3) check({p, "_neg"}, 32'(n), 32'(m_neg[c]));
  endtask

  task automatic check_idle(input string tag);
    check_cfg(tag, 0, stage3, 32'(op_a3), 32'(op_b3), 32'(cdu3), neg3, sub3, done3);
    check_cfg(tag, 1, stage5, 32'(op_a5), 32'(op_b5), 32'(cdu5), neg5, sub5, done5);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample = 4'hF;
    prev_key = 4'hF;
    repeat (3) @(negedge clk);
    model_reset();
    q3.delete();
    q5.delete();
    calc_flag = 1'b0;
    rst = 1'b0;
  endtask

  // Monitors: on each rising done, pop the expected result and compare,
  // and confirm CALC lasted DIGITS+1 clocks.
  initial begin : mon3
    logic prev;
    int   len;
    exp_t e;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (done3 && !prev) begin
        check("calc_len_d3", 32'(len), 32'd4);
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done_d3: actual=done expected=no_result_pending");
        end else begin
          e = q3.pop_front();
          check("res_cdu_d3", 32'(cdu3), e.cdu);
          check("res_neg_d3", 32'(neg3), 32'(e.neg));
          check("res_op_a_d3", 32'(op_a3), e.a);
          check("res_op_b_d3", 32'(op_b3), e.b);
        end
      end
      len  = (stage3 == 2'd2) ? len + 1 : 0;
      prev = done3;
    end
  end

  initial begin : mon5
    logic prev;
    int   len;
    exp_t e;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (done5 && !prev) begin
        check("calc_len_d5", 32'(len), 32'd6);
        if (q5.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done_d5: actual=done expected=no_result_pending");
        end else begin
          e = q5.pop_front();
          check("res_cdu_d5", 32'(cdu5), e.cdu);
          check("res_neg_d5", 32'(neg5), 32'(e.neg));
          check("res_op_a_d5", 32'(op_a5), e.a);
          check("res_op_b_d5", 32'(op_b5), e.b);
        end
      end
      len  = (stage5 == 2'd2) ? len + 1 : 0;
      prev = done5;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic found;
    logic [3:0] r_key;
    int sel;

    do_reset();
    drive(4'hF);
    check_idle("reset");

    // 534 + 961
    keys('{4'h5, 4'h3, 4'h4, 4'h9, 4'h6, 4'h1});
    check("add1_cdu", 32'(cdu3), 32'h1495);
    check("add1_op_a", 32'(op_a3), 32'h534);
    check("add1_op_b", 32'(op_b3), 32'h961);
    check_idle("add1");
    press(4'hE, 1, 3);

    // 999 + 999: overflow into the top digit
    keys('{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9});
    check("add999_cdu", 32'(cdu3), 32'h1998);
    check_idle("add999");
    press(4'hE, 1, 3);

    // Subtract both orderings, then equal operands
    keys('{4'hB, 4'h5, 4'h3, 4'h4, 4'h9, 4'h6, 4'h1});
    check("sub1_cdu", 32'(cdu3), 32'h0427);
    check("sub1_neg", 32'(neg3), 32'd1);
    check("sub1_mode", 32'(sub3), 32'd1);
    keys('{4'hB, 4'h9, 4'h6, 4'h1, 4'h5, 4'h3, 4'h4});
    check("sub2_cdu", 32'(cdu3), 32'h0427);
    check("sub2_neg", 32'(neg3), 32'd0);
    keys('{4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0});
    check("sub3_cdu", 32'(cdu3), 32'h0);
    check("sub3_neg", 32'(neg3), 32'd0);
    check_idle("sub");
    press(4'hE, 1, 3);

    // Short operands: 7 + 25
    keys('{4'hA, 4'h7, 4'hC, 4'h2, 4'h5, 4'hC});
    check("short_op_a", 32'(op_a3), 32'h007);
    check("short_op_b", 32'(op_b3), 32'h025);
    check("short_cdu", 32'(cdu3), 32'h0032);
    check("short_cdu_d5", 32'(cdu5), 32'h000032);
    check_idle("short");
    press(4'hE, 1, 3);

    // Held key, code change without release, ignored code
    press(4'h3, 50, 3);
    check("hold_op_a", 32'(op_a3), 32'h003);
    repeat (5) drive(4'h3);
    press(4'h4, 5, 3);
    check("glitch_op_a", 32'(op_a3), 32'h033);
    press(4'hD, 2, 3);
    check("keyd_op_a", 32'(op_a3), 32'h033);
    check_idle("hold");

    // Clear mid-entry
    keys('{4'hE, 4'h1, 4'h2, 4'hE});
    check("clr_op_a", 32'(op_a3), 32'h0);
    check("clr_stage", 32'(stage3), 32'd0);
    check_idle("clear");

    // Reset in the second CALC cycle of the 3-digit instance
    keys('{4'h5, 4'h3, 4'h4, 4'h9, 4'h6});
    drive(4'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(4'hF);
      if (stage3 == 2'd2) found = 1'b1;
    end
    check("reach_calc_d3", 32'(stage3), 32'd2);
    drive(4'hF);
    rst = 1'b1;
    @(negedge clk);
    check("rstcalc_stage", 32'(stage3), 32'd0);
    check("rstcalc_cdu", 32'(cdu3), 32'h0);
    check("rstcalc_op_a", 32'(op_a3), 32'h0);
    check("rstcalc_op_b", 32'(op_b3), 32'h0);
    check("rstcalc_neg", 32'(neg3), 32'd0);
    check("rstcalc_done", 32'(done3), 32'd0);
    check("rstcalc_op_a_d5", 32'(op_a5), 32'h0);
    do_reset();
    drive(4'hF);
    check_idle("after_rst");

    // 53400 + 96100 on the 5-digit instance
    keys('{4'h5, 4'h3, 4'h4, 4'h0, 4'h0, 4'h9, 4'h6, 4'h1, 4'h0, 4'h0});
    check("d5_cdu", 32'(cdu5), 32'h149500);
    check("d5_op_a", 32'(op_a5), 32'h53400);
    check("d5_op_b", 32'(op_b5), 32'h96100);
    check_idle("d5");

    // Random key stream against the model
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 19);
      r_key = 4'($urandom_range(0, 9));
      if (sel <= 11)      press(r_key, $urandom_range(1, 3), $urandom_range(2, 4));
      else if (sel == 12) press(4'hA, 1, 2);
      else if (sel == 13) press(4'hB, 1, 2);
      else if (sel <= 15) press(4'hC, $urandom_range(1, 3), 2);
      else if (sel == 16) press(4'hE, 1, 2);
      else if (sel == 17) press(4'hD, 2, 2);
      else begin
        repeat ($urandom_range(1, 3)) drive(r_key);
        press(4'($urandom_range(0, 9)), 2, 3);
      end
      check_idle("rnd");
    end

    repeat (20) drive(4'hF);
    check("drained_d3", 32'(q3.size()), 32'd0);
    check("drained_d5", 32'(q5.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_key_calc.md
# bcd_key_calc

Parametrised successor of the keypad BCD adder. It captures two decimal operands of `DIGITS` digits each, one key code at a time, from the keypad scan path. It then adds or subtracts them with a digit-serial BCD datapath and presents a `DIGITS+1` digit BCD result plus a sign flag to the 7-segment display driver. Each key press is counted once, however long it is held. Operands can be shorter than `DIGITS` digits, and a clear key resets entry.

## Interface
- `DIGITS`, default 3: decimal digits per operand, legal range 1–8.
- `clk` in 1: system clock, 27 MHz.
- `rst` in 1: synchronous, active-high reset.
- `sample` in 4: keypad key code; 4'hF means no key.
- `op_a` out 4·DIGITS: operand A, BCD, MSD in the top nibble.
- `op_b` out 4·DIGITS: operand B, BCD.
- `cdu` out 4·(DIGITS+1): result magnitude, BCD.
- `neg` out 1: result is negative (subtract with A < B).
- `sub_mode` out 1: latched operation; 0 = add, 1 = subtract.
- `stage` out 2: 0 = ENTER_A, 1 = ENTER_B, 2 = CALC, 3 = SHOW.
- `done` out 1: high while in SHOW.

## Operation
- Key codes: 4'h0–4'h9 are digits, 4'hA selects add, 4'hB selects subtract, 4'hC ends the current operand, 4'hE clears, 4'hF is idle. 4'hD is ignored in all states.
- Input conditioning:
  - `sample` is registered into `s_q`, and `s_q` into `s_qq`.
  - A press event occurs in the cycle where `s_q != F` and `s_qq == F`.
  - A held key produces exactly one event. Changing from one non-F code to another non-F code without passing through F produces no event.
- ENTER_A and ENTER_B: digit entry
  - On a digit event, the active operand shifts left one nibble and the digit enters the low nibble.
  - After the DIGITS-th digit, or on 4'hC, ENTER_A goes to ENTER_B, and ENTER_B goes to CALC.
  - 4'hC with zero digits entered gives an operand value of 0.
- ENTER_A and ENTER_B: other keys
  - 4'hA and 4'hB set `sub_mode` and do not change state.
  - 4'hE zeroes `op_a`, `op_b`, `cdu` and `neg`, and returns to ENTER_A. `sub_mode` is kept.
- CALC: operand ordering
  - Entered on the edge that completes B.
  - Add mode: X = A, Y = B, `neg` = 0.
  - Subtract mode: compare A and B as unsigned vectors, which is valid for BCD. If A < B, then X = B, Y = A, `neg` = 1; otherwise X = A, Y = B, `neg` = 0.
- CALC: digit-serial datapath
  - A digit counter `k` runs from 0 (LSD) to DIGITS-1, one digit per clock.
  - Each clock produces `cdu` nibble k = X[k] ± Y[k] ± carry/borrow, with a BCD correction of +6 when the sum exceeds 9, or +10 when the difference is below 0.
  - The carry/borrow is registered between digits.
  - On the cycle after k = DIGITS-1, the final carry goes into the top nibble of `cdu` and the block moves to SHOW. In subtract mode the top nibble is always 0.
  - All keys are ignored during CALC.
- SHOW:
  - `cdu`, `neg`, `op_a` and `op_b` hold their values.
  - A digit event clears the operands and `cdu`, loads the digit into `op_a`, and goes to ENTER_A.
  - 4'hE clears everything and goes to ENTER_A.
  - 4'hA and 4'hB set `sub_mode`.
  - 4'hC is ignored.
- Reset, applied in any state including mid-CALC:
  - `stage` = ENTER_A.
  - `op_a`, `op_b`, `cdu`, `neg`, `sub_mode`, `done`, the digit counters and the carry register are all 0.
  - `s_q` and `s_qq` are 4'hF, so a key held through reset generates no event until it is released.

## Timing
- A change on `sample` reaches `s_q` after 1 clock. The press event is seen in that cycle, and the operand or state update appears on the next edge: 2 clocks from `sample` to `op_a`/`op_b`.
- CALC lasts exactly DIGITS+1 clocks. `done` rises DIGITS+1 clocks after `stage` first reads 2.
- Operand ordering and `neg` are registered on the ENTER_B→CALC edge.
- `cdu` nibbles update progressively during CALC. They are valid only when `done` = 1.
- No combinational path exists from `sample` to any output.

## Structure
- Package `bcd_calc_pkg` contains:
  - key code constants `KEY_NONE`, `KEY_ADD`, `KEY_SUB`, `KEY_END`, `KEY_CLR`;
  - the `stage_t` enum: ENTER_A, ENTER_B, CALC, SHOW.
- Sub-module `bcd_digit_alu` is combinational. It takes a 4-bit a and b, `cin`, and `sub`, and returns a 4-bit digit and `cout`. It is instantiated once.
- The top level contains the input synchroniser, the edge detector, the FSM, the operand shift registers and the serial counter.

## Test plan
- DIGITS=3, add: keys 5,3,4,9,6,1, each followed by 4'hF → `op_a`=12'h534, `op_b`=12'h961, `cdu`=16'h1495, `neg`=0. `done` rises 4 clocks after CALC entry.
- DIGITS=3, add: 9,9,9,9,9,9 → `cdu`=16'h1998. Overflow lands in the top digit.
- DIGITS=3: key B, then 5,3,4,9,6,1 → `sub_mode`=1, `cdu`=16'h0427, `neg`=1. Then key B, then 9,6,1,5,3,4 → `cdu`=16'h0427, `neg`=0. Then 2,0,0,2,0,0 (in subtract mode) → `cdu`=0, `neg`=0.
- DIGITS=3, short operands: key A, then 7,C,2,5,C → `op_a`=12'h007, `op_b`=12'h025, `cdu`=16'h0032.
- Held key and glitch handling: hold 4'h3 for 50 clocks → exactly one digit entered. Switching 4'h3→4'h4 with no 4'hF in between → no second digit. 4'hD → no effect.
- Clear and reset: 1,2,E → all operands 0, ENTER_A. Assert `rst` in the 2nd CALC cycle → every output 0, `stage`=0. Repeat the first scenario with DIGITS=5 (operands 53400 + 96100) → `cdu`=24'h149500.
